reg_file_mp: RTL and testbench

- Parametrised 2-read / 1-write CPU register file for the single-cycle core; next generation of the 8-entry datapath register file.
- Adds a separate write address, a synchronous reset, a hardware clear sweep after reset with a busy flag, and an optional hardwired-zero register 0.
- Sits between instruction decode (ra/rb/rw) and the ALU/writeback path (busa/busb/busw).

---
 rtl/reg_file_mp_pkg.sv | 19 +
 rtl/reg_file_mp_if.sv | 22 ++
 rtl/reg_file_mp_clear_seq.sv | 51 +++++
 rtl/reg_file_mp.sv | 84 ++++++++
 tb/tb_reg_file_mp.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the sequencer state encoding and the write-legality rule used by the write path and forwarding.
package reg_file_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 5;

  // A write lands only in RUN, inside the populated range, and never on a hardwired zero register.
  function automatic logic legal_wr(input logic [31:0] rw, input logic we, input state_e state,
                                    input int unsigned depth, input logic zero_reg);
    return we && (state == ST_RUN) && (rw < depth) && !(zero_reg && (rw == 32'd0));
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-side bus of the register file.
// The master is the core (addresses, write data); the slave is the register file.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
);

  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] rw;
  logic [DATA_W-1:0] busw;
  logic              we;
  logic [DATA_W-1:0] busa;
  logic [DATA_W-1:0] busb;
  logic              busy;

  modport master (output ra, rb, rw, busw, we, input busa, busb, busy);
  modport slave  (input ra, rb, rw, busw, we, output busa, busb, busy);

endinterface

// File: rtl/reg_file_mp_clear_seq.sv
// Post-reset clear sequencer: walks every register address once, then hands the file over to RUN.
// A reset arriving mid-sweep restarts the walk from address 0.
module reg_clear_seq
  import reg_file_pkg::*;
#(
  parameter int          ADDR_W = ADDR_W_D,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // The reset cycle itself must leave register contents untouched.
  assign busy     = busy_q;
  assign clr_we   = busy_q && !rst;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// 2-read / 1-write register file with a hardware clear sweep after reset and optional hardwired zero register.
// Define REG_FILE_MP_BYPASS_EN for write-first forwarding of a legal write onto matching read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int          DATA_W   = DATA_W_D,
  parameter int          ADDR_W   = ADDR_W_D,
  parameter int unsigned DEPTH    = 1 << ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  reg_file_mp_if.slave        bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  state_e            cur_state;
  logic              wr_legal;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] busa_d;
  logic [DATA_W-1:0] busb_d;

  reg_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign cur_state = busy ? ST_CLEAR : ST_RUN;
  assign wr_legal  = legal_wr(32'(bus.rw), bus.we, cur_state, DEPTH, ZERO_REG);

  // The sweep owns the write port while busy; otherwise the core's write goes through.
  always_comb begin
    wr_en   = clr_we;
    wr_addr = clr_addr;
    wr_data = '0;
    if (!clr_we && wr_legal && !rst) begin
      wr_en   = 1'b1;
      wr_addr = bus.rw;
      wr_data = bus.busw;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] data;
    data = '0;
    if (!busy && (32'(addr) < DEPTH) && !(ZERO_REG && (addr == '0))) begin
      data = mem_q[addr];
    end
`ifdef REG_FILE_MP_BYPASS_EN
    if (wr_legal && (bus.rw == addr)) begin
      data = bus.busw;
    end
`endif
    return data;
  endfunction

  always_comb begin
    busa_d = read_port(bus.ra);
    busb_d = read_port(bus.rb);
  end

  assign bus.busa = busa_d;
  assign bus.busb = busb_d;
  assign bus.busy = busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: three instances (default, ZERO_REG=0, DEPTH=24) share one stimulus stream
// and are compared against a behavioural model of register contents and sweep length.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  s_ra = '0, s_rb = '0, s_rw = '0;
  logic [31:0] s_busw = '0;
  logic        s_we = 1'b0;

  int checks = 0;
  int errors = 0;

  int unsigned depth_m [3] = '{32, 32, 24};
  bit          zero_m  [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mem_m   [3][32];
  int          remaining [3] = '{0, 0, 0};
  logic        obs_busy0;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) if2 ();

  assign if0.ra = s_ra;  assign if0.rb = s_rb;  assign if0.rw = s_rw;  assign if0.busw = s_busw;  assign if0.we = s_we;
  assign if1.ra = s_ra;  assign if1.rb = s_rb;  assign if1.rw = s_rw;  assign if1.busw = s_busw;  assign if1.we = s_we;
  assign if2.ra = s_ra;  assign if2.rb = s_rb;  assign if2.rw = s_rw;  assign if2.busw = s_busw;  assign if2.we = s_we;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .ZERO_REG(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Reference model: a write lands if the file is out of its clear period and the address is real and writable.
  function automatic bit legalModel(int d);
    return (remaining[d] == 0) && s_we && (32'(s_rw) < depth_m[d]) && !(zero_m[d] && s_rw == 5'd0);
  endfunction

  function automatic logic [31:0] expRead(int d, logic [4:0] a);
    if (remaining[d] != 0) return 32'h0;
    if (32'(a) >= depth_m[d]) return 32'h0;
    if (zero_m[d] && a == 5'd0) return 32'h0;
`ifdef REG_FILE_MP_BYPASS_EN
    if (legalModel(d) && s_rw == a) return s_busw;
`endif
    return mem_m[d][a];
  endfunction

  // After a reset the file is unusable for DEPTH clocks, then every register holds zero.
  task automatic modelEdge();
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        remaining[d] = depth_m[d];
      end else if (remaining[d] != 0) begin
        remaining[d]--;
        if (remaining[d] == 0) begin
          for (int i = 0; i < 32; i++) mem_m[d][i] = 32'h0;
        end
      end else if (legalModel(d)) begin
        mem_m[d][s_rw] = s_busw;
      end
    end
  endtask

  function automatic logic [31:0] obsA(int d);
    case (d)
      0: return if0.busa;
      1: return if1.busa;
      default: return if2.busa;
    endcase
  endfunction

  function automatic logic [31:0] obsB(int d);
    case (d)
      0: return if0.busb;
      1: return if1.busb;
      default: return if2.busb;
    endcase
  endfunction

  function automatic logic obsBusy(int d);
    case (d)
      0: return if0.busy;
      1: return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  task automatic applyStimulus(input logic r, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] w, input logic [31:0] data, input logic wen);
    rst    = r;
    s_ra   = a;
    s_rb   = b;
    s_rw   = w;
    s_busw = data;
    s_we   = wen;
  endtask

  task automatic checkOutput(input string tag);
    for (int d = 0; d < 3; d++) begin
      logic [31:0] ea, eb, oa, ob;
      logic        ey, oy;
      ea = expRead(d, s_ra);
      eb = expRead(d, s_rb);
      ey = (remaining[d] != 0);
      oa = obsA(d);
      ob = obsB(d);
      oy = obsBusy(d);
      checks++;
      assert (oa === ea) else begin
        errors++;
        $error("[TB] FAIL %s dut%0d busa ra=%0d observed=%h expected=%h", tag, d, s_ra, oa, ea);
      end
      checks++;
      assert (ob === eb) else begin
        errors++;
        $error("[TB] FAIL %s dut%0d busb rb=%0d observed=%h expected=%h", tag, d, s_rb, ob, eb);
      end
      checks++;
      assert (oy === ey) else begin
        errors++;
        $error("[TB] FAIL %s dut%0d busy observed=%b expected=%b", tag, d, oy, ey);
      end
    end
    obs_busy0 = if0.busy;
  endtask

  task automatic checkConst(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                       input logic [31:0] data, input logic wen, input string tag);
    @(negedge clk);
    applyStimulus(r, a, b, w, data, wen);
    #1;
    checkOutput(tag);
    @(posedge clk);
    modelEdge();
  endtask

  // Counts the reset cycle plus every following cycle the default instance reports busy; bounded.
  task automatic countSweep(input string tag);
    int busy_cnt;
    busy_cnt = 1;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'd3, 32'hDEADBEEF, 1'(i < 31), tag);
      if (!obs_busy0) break;
      busy_cnt++;
    end
    checks++;
    assert (busy_cnt === 33) else begin
      errors++;
      $error("[TB] FAIL %s busy_cycles observed=%0d expected=%0d", tag, busy_cnt, 33);
    end
  endtask

  initial begin
    // Power-up state is undefined, so the first reset is applied without comparing outputs.
    @(negedge clk);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    @(posedge clk);
    modelEdge();
    countSweep("sweep0");
    checkConst("lost_write_dut0", if0.busa, 32'h0);

    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
            $urandom, 1'b1, "preload");
    end

    cycle(1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 1'b0, "rst1");
    countSweep("sweep1");
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, "clear_rd");
    end
    cycle(1'b0, 5'd3, 5'd4, 5'd0, 32'h0, 1'b0, "lost_rd");
    #1 checkConst("deadbeef_lost", if0.busa, 32'h0);

    cycle(1'b0, 5'd5, 5'd5, 5'd5, 32'h12345678, 1'b1, "wr5");
    cycle(1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 1'b0, "rd5");
    #1 checkConst("rd5_busa", if0.busa, 32'h12345678);
    checkConst("rd5_busb", if0.busb, 32'h12345678);

    cycle(1'b0, 5'd0, 5'd1, 5'd0, 32'hFFFFFFFF, 1'b1, "wr0");
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, "rd0");
    #1 checkConst("zero_reg_on", if0.busa, 32'h0);
    checkConst("zero_reg_off", if1.busa, 32'hFFFFFFFF);

    cycle(1'b0, 5'd8, 5'd8, 5'd8, 32'h88888888, 1'b1, "wr8");
    cycle(1'b0, 5'd7, 5'd8, 5'd7, 32'hA5A5A5A5, 1'b1, "byp7");
    cycle(1'b0, 5'd0, 5'd8, 5'd0, 32'hA5A5A5A5, 1'b1, "byp0");

    cycle(1'b0, 5'd30, 5'd23, 5'd30, 32'hCAFE0030, 1'b1, "wr30");
    cycle(1'b0, 5'd30, 5'd23, 5'd23, 32'hCAFE0023, 1'b1, "wr23");
    cycle(1'b0, 5'd30, 5'd23, 5'd0, 32'h0, 1'b0, "rd30");
    #1 checkConst("oor_read", if2.busa, 32'h0);
    checkConst("last_reg", if2.busb, 32'hCAFE0023);

    cycle(1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 1'b0, "rst2");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'd9, 32'h99, 1'b1, "mid");
    end
    cycle(1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 1'b0, "rst_mid");
    countSweep("midsweep");

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(99) == 0), 5'($urandom_range(31)), 5'($urandom_range(31)),
            5'($urandom_range(31)), $urandom, 1'($urandom_range(1)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
